// File: rtl/lsu_mem_stage.sv
// Load/store memory stage: issues one data-memory access per instruction and produces a one-cycle writeback pulse.
// Optional macro LSU_MISALIGN_TRAP_EN turns misaligned half/word accesses into a misalign completion without a bus request.
module lsu_mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid_i,
  output logic        ex_ready_o,
  input  logic [7:0]  load_store_info_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] store_data_i,
  input  logic [4:0]  rd_i,
  output logic        dmem_req_o,
  input  logic        dmem_gnt_i,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  output logic [3:0]  dmem_wstrb_o,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        wb_valid_o,
  output logic        wb_we_o,
  output logic [4:0]  wb_rd_o,
  output logic [31:0] wb_data_o,
  output logic        misalign_o
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  off_q, off_d;
  logic [7:0]  info_q, info_d;
  logic [4:0]  rd_q, rd_d;
  logic        we_q, we_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        wb_valid_q, wb_valid_d;
  logic        wb_we_q, wb_we_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        misalign_q, misalign_d;

  logic        mis_acc;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] load_v;

`ifdef LSU_MISALIGN_TRAP_EN
  assign mis_acc = ((load_store_info_i[6] | load_store_info_i[3] | load_store_info_i[1]) & mem_addr_i[0]) |
                   ((load_store_info_i[5] | load_store_info_i[0]) & (mem_addr_i[1:0] != 2'b00));
`else
  assign mis_acc = 1'b0;
`endif

  assign ex_ready_o   = (state_q == S_IDLE) && !rst;
  assign dmem_req_o   = (state_q == S_REQ);
  assign dmem_we_o    = we_q;
  assign dmem_addr_o  = addr_q;
  assign dmem_wdata_o = wdata_q;
  assign dmem_wstrb_o = wstrb_q;
  assign wb_valid_o   = wb_valid_q;
  assign wb_we_o      = wb_we_q;
  assign wb_rd_o      = wb_rd_q;
  assign wb_data_o    = wb_data_q;
  assign misalign_o   = misalign_q;

  // Byte lane selected by addr[1:0], halfword lane by addr[1] only.
  always_comb begin
    byte_v = 8'(dmem_rdata_i >> {off_q, 3'b000});
    half_v = 16'(dmem_rdata_i >> {off_q[1], 4'b0000});
    if (info_q[7])      load_v = {{24{byte_v[7]}}, byte_v};
    else if (info_q[6]) load_v = {{16{half_v[15]}}, half_v};
    else if (info_q[4]) load_v = {24'h0, byte_v};
    else if (info_q[3]) load_v = {16'h0, half_v};
    else                load_v = dmem_rdata_i;
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    off_d      = off_q;
    info_d     = info_q;
    rd_d       = rd_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    wb_valid_d = 1'b0;
    wb_we_d    = wb_we_q;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    misalign_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (ex_valid_i) begin
          if (load_store_info_i == 8'h00) begin
            wb_valid_d = 1'b1;
            wb_we_d    = (rd_i != 5'd0);
            wb_rd_d    = rd_i;
            wb_data_d  = alu_result_i;
          end else if (mis_acc) begin
            wb_valid_d = 1'b1;
            wb_we_d    = 1'b0;
            wb_rd_d    = rd_i;
            wb_data_d  = mem_addr_i;
            misalign_d = 1'b1;
          end else begin
            state_d = S_REQ;
            addr_d  = {mem_addr_i[31:2], 2'b00};
            off_d   = mem_addr_i[1:0];
            info_d  = load_store_info_i;
            rd_d    = rd_i;
            we_d    = |load_store_info_i[2:0];
            wdata_d = '0;
            wstrb_d = '0;
            if (load_store_info_i[2]) begin
              wdata_d = {4{store_data_i[7:0]}};
              wstrb_d = 4'b0001 << mem_addr_i[1:0];
            end else if (load_store_info_i[1]) begin
              wdata_d = {2{store_data_i[15:0]}};
              wstrb_d = 4'b0011 << {mem_addr_i[1], 1'b0};
            end else if (load_store_info_i[0]) begin
              wdata_d = store_data_i;
              wstrb_d = 4'b1111;
            end
          end
        end
      end
      S_REQ: begin
        if (dmem_gnt_i) begin
          if (we_q) begin
            state_d    = S_IDLE;
            wb_valid_d = 1'b1;
            wb_we_d    = 1'b0;
            wb_rd_d    = rd_q;
            wb_data_d  = '0;
          end else begin
            state_d = S_RESP;
          end
        end
      end
      S_RESP: begin
        if (dmem_rvalid_i) begin
          state_d    = S_IDLE;
          wb_valid_d = 1'b1;
          wb_we_d    = (rd_q != 5'd0);
          wb_rd_d    = rd_q;
          wb_data_d  = load_v;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      off_q      <= '0;
      info_q     <= '0;
      rd_q       <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      wb_valid_q <= 1'b0;
      wb_we_q    <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      off_q      <= off_d;
      info_q     <= info_d;
      rd_q       <= rd_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      wb_valid_q <= wb_valid_d;
      wb_we_q    <= wb_we_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      misalign_q <= misalign_d;
    end
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage: ALU passthrough, load extraction, store lanes, handshake stalls and reset abort.
module tb_lsu_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid_i;
  logic        ex_ready_o;
  logic [7:0]  load_store_info_i;
  logic [31:0] mem_addr_i;
  logic [31:0] alu_result_i;
  logic [31:0] store_data_i;
  logic [4:0]  rd_i;
  logic        dmem_req_o;
  logic        dmem_gnt_i;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [31:0] dmem_wdata_o;
  logic [3:0]  dmem_wstrb_o;
  logic        dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic        wb_valid_o;
  logic        wb_we_o;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;
  logic        misalign_o;

  int checks = 0;
  int failures = 0;

  localparam logic [7:0] LB = 8'h80, LH = 8'h40, LW = 8'h20, LBU = 8'h10, LHU = 8'h08;
  localparam logic [7:0] SB = 8'h04, SH = 8'h02, SW = 8'h01;

  lsu_mem_stage dut (
    .clk(clk), .rst(rst), .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o),
    .load_store_info_i(load_store_info_i), .mem_addr_i(mem_addr_i),
    .alu_result_i(alu_result_i), .store_data_i(store_data_i), .rd_i(rd_i),
    .dmem_req_o(dmem_req_o), .dmem_gnt_i(dmem_gnt_i), .dmem_we_o(dmem_we_o),
    .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o), .dmem_wstrb_o(dmem_wstrb_o),
    .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
    .wb_valid_o(wb_valid_o), .wb_we_o(wb_we_o), .wb_rd_o(wb_rd_o),
    .wb_data_o(wb_data_o), .misalign_o(misalign_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one instruction for a single cycle while the stage is idle.
  task automatic accept(input logic [7:0] info, input logic [31:0] addr, input logic [31:0] alu,
                        input logic [31:0] sdata, input logic [4:0] rd);
    ex_valid_i        = 1'b1;
    load_store_info_i = info;
    mem_addr_i        = addr;
    alu_result_i      = alu;
    store_data_i      = sdata;
    rd_i              = rd;
    step();
    ex_valid_i        = 1'b0;
    load_store_info_i = 8'h00;
  endtask

  // Load with immediate grant and read data one cycle later; checks the completion.
  task automatic load_chk(input string tag, input logic [7:0] info, input logic [31:0] addr,
                          input logic [31:0] rdata, input logic [31:0] exp);
    accept(info, addr, 32'h0, 32'h0, 5'd9);
    dmem_gnt_i = 1'b1;
    step();
    dmem_gnt_i    = 1'b0;
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = rdata;
    step();
    dmem_rvalid_i = 1'b0;
    chk({tag, "_valid"}, 32'(wb_valid_o), 32'h1);
    chk({tag, "_data"}, wb_data_o, exp);
  endtask

  initial begin
    rst = 1'b1; ex_valid_i = 1'b0; load_store_info_i = 8'h00; mem_addr_i = '0;
    alu_result_i = '0; store_data_i = '0; rd_i = '0; dmem_gnt_i = 1'b0;
    dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
    step(); step();
    chk("rst_ready", 32'(ex_ready_o), 32'h0);
    chk("rst_req", 32'(dmem_req_o), 32'h0);
    chk("rst_wb_valid", 32'(wb_valid_o), 32'h0);
    chk("rst_addr", dmem_addr_o, 32'h0);
    chk("rst_wstrb", 32'(dmem_wstrb_o), 32'h0);
    chk("rst_misalign", 32'(misalign_o), 32'h0);
    rst = 1'b0;
    #1;
    chk("idle_ready", 32'(ex_ready_o), 32'h1);

    // Non-memory instruction, then rd=0 variant
    accept(8'h00, 32'h0, 32'h12345678, 32'h0, 5'd3);
    chk("alu_valid", 32'(wb_valid_o), 32'h1);
    chk("alu_data", wb_data_o, 32'h12345678);
    chk("alu_we", 32'(wb_we_o), 32'h1);
    chk("alu_rd", 32'(wb_rd_o), 32'd3);
    chk("alu_ready", 32'(ex_ready_o), 32'h1);
    accept(8'h00, 32'h0, 32'hA5A5A5A5, 32'h0, 5'd0);
    chk("alu_r0_we", 32'(wb_we_o), 32'h0);
    chk("alu_r0_data", wb_data_o, 32'hA5A5A5A5);
    step();
    chk("alu_pulse_once", 32'(wb_valid_o), 32'h0);

    // Grant in IDLE must be ignored
    dmem_gnt_i = 1'b1;
    step();
    dmem_gnt_i = 1'b0;
    chk("gnt_idle_req", 32'(dmem_req_o), 32'h0);
    chk("gnt_idle_wb", 32'(wb_valid_o), 32'h0);

    // lw 0x100, minimum latency
    accept(LW, 32'h100, 32'h0, 32'h0, 5'd5);
    chk("lw_req", 32'(dmem_req_o), 32'h1);
    chk("lw_addr", dmem_addr_o, 32'h100);
    chk("lw_we", 32'(dmem_we_o), 32'h0);
    chk("lw_busy", 32'(ex_ready_o), 32'h0);
    dmem_gnt_i = 1'b1;
    step();
    dmem_gnt_i = 1'b0;
    chk("lw_req_drop", 32'(dmem_req_o), 32'h0);
    chk("lw_n2_wb", 32'(wb_valid_o), 32'h0);
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = 32'hDEADBEEF;
    step();
    dmem_rvalid_i = 1'b0;
    chk("lw_valid", 32'(wb_valid_o), 32'h1);
    chk("lw_data", wb_data_o, 32'hDEADBEEF);
    chk("lw_we_wb", 32'(wb_we_o), 32'h1);
    chk("lw_rd", 32'(wb_rd_o), 32'd5);
    chk("lw_ready", 32'(ex_ready_o), 32'h1);

    // Load extraction variants
    load_chk("lb", LB, 32'h203, 32'h80FFFF00, 32'hFFFFFF80);
    load_chk("lbu", LBU, 32'h203, 32'h80FFFF00, 32'h00000080);
    load_chk("lb0", LB, 32'h200, 32'h80FFFF7F, 32'h0000007F);
    load_chk("lh", LH, 32'h202, 32'h80FFFF00, 32'hFFFF80FF);
    load_chk("lhu", LHU, 32'h200, 32'h80FFFF00, 32'h0000FF00);

    // rvalid during REQ ignored; response after a 2-cycle wait
    accept(LW, 32'h300, 32'h0, 32'h0, 5'd0);
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = 32'h11111111;
    step();
    dmem_rvalid_i = 1'b0;
    chk("rv_in_req", 32'(dmem_req_o), 32'h1);
    dmem_gnt_i = 1'b1;
    step();
    dmem_gnt_i = 1'b0;
    step(); step();
    chk("resp_wait", 32'(wb_valid_o), 32'h0);
    chk("resp_wait_ready", 32'(ex_ready_o), 32'h0);
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = 32'h76543210;
    step();
    dmem_rvalid_i = 1'b0;
    chk("lw_r0_data", wb_data_o, 32'h76543210);
    chk("lw_r0_we", 32'(wb_we_o), 32'h0);

    // sh 0x402 with 3-cycle grant delay
    accept(SH, 32'h402, 32'h0, 32'h1234ABCD, 5'd4);
    for (int i = 0; i < 3; i++) begin
      chk("sh_req", 32'(dmem_req_o), 32'h1);
      chk("sh_addr", dmem_addr_o, 32'h400);
      chk("sh_wdata", dmem_wdata_o, 32'hABCDABCD);
      chk("sh_wstrb", 32'(dmem_wstrb_o), 32'hC);
      chk("sh_we", 32'(dmem_we_o), 32'h1);
      chk("sh_nowb", 32'(wb_valid_o), 32'h0);
      step();
    end
    dmem_gnt_i = 1'b1;
    chk("sh_req_gnt", 32'(dmem_req_o), 32'h1);
    step();
    dmem_gnt_i = 1'b0;
    chk("sh_valid", 32'(wb_valid_o), 32'h1);
    chk("sh_wb_we", 32'(wb_we_o), 32'h0);
    chk("sh_req_done", 32'(dmem_req_o), 32'h0);
    chk("sh_ready", 32'(ex_ready_o), 32'h1);

    // Back-to-back: sb accepted in the sh completion cycle
    accept(SB, 32'h501, 32'h0, 32'hCAFE005A, 5'd1);
    chk("sb_addr", dmem_addr_o, 32'h500);
    chk("sb_wdata", dmem_wdata_o, 32'h5A5A5A5A);
    chk("sb_wstrb", 32'(dmem_wstrb_o), 32'h2);
    dmem_gnt_i = 1'b1;
    step();
    dmem_gnt_i = 1'b0;
    chk("sb_valid", 32'(wb_valid_o), 32'h1);

    accept(SW, 32'h600, 32'h0, 32'h89ABCDEF, 5'd1);
    chk("sw_wdata", dmem_wdata_o, 32'h89ABCDEF);
    chk("sw_wstrb", 32'(dmem_wstrb_o), 32'hF);
    dmem_gnt_i = 1'b1;
    step();
    dmem_gnt_i = 1'b0;
    chk("sw_valid", 32'(wb_valid_o), 32'h1);

    // Misaligned lw 0x101
    accept(LW, 32'h101, 32'h0, 32'h0, 5'd7);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("mis_req", 32'(dmem_req_o), 32'h0);
    chk("mis_valid", 32'(wb_valid_o), 32'h1);
    chk("mis_flag", 32'(misalign_o), 32'h1);
    chk("mis_data", wb_data_o, 32'h101);
    chk("mis_we", 32'(wb_we_o), 32'h0);
    step();
    chk("mis_req_after", 32'(dmem_req_o), 32'h0);
`else
    chk("mis_req", 32'(dmem_req_o), 32'h1);
    chk("mis_addr", dmem_addr_o, 32'h100);
    dmem_gnt_i = 1'b1;
    step();
    dmem_gnt_i    = 1'b0;
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = 32'hCAFEF00D;
    step();
    dmem_rvalid_i = 1'b0;
    chk("mis_data", wb_data_o, 32'hCAFEF00D);
    chk("mis_flag", 32'(misalign_o), 32'h0);
`endif

    // Reset while in RESP, late rvalid ignored
    accept(LW, 32'h700, 32'h0, 32'h0, 5'd6);
    dmem_gnt_i = 1'b1;
    step();
    dmem_gnt_i = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = 32'h55555555;
    #1;
    chk("rstm_ready", 32'(ex_ready_o), 32'h1);
    chk("rstm_addr", dmem_addr_o, 32'h0);
    step();
    dmem_rvalid_i = 1'b0;
    chk("rstm_nowb", 32'(wb_valid_o), 32'h0);
    chk("rstm_req", 32'(dmem_req_o), 32'h0);
    chk("rstm_ready2", 32'(ex_ready_o), 32'h1);
    step();
    chk("rstm_nowb2", 32'(wb_valid_o), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
